// File: rtl/noc_port_arbiter_if.sv
// Request/grant bundle between the NoC port requesters and the output-port arbiter.
// The arbiter takes the slave side; requesters and status consumers take the master side.
interface noc_port_arbiter_if #(
   parameter int unsigned NREQ      = 5,
   parameter int unsigned CNT_WIDTH = 16
);
   logic [NREQ-1:0]      req;
   logic [NREQ-1:0]      last;
   logic                 xfer;
   logic                 enable;
   logic [NREQ-1:0]      gnt;
   logic [2:0]           gnt_id;
   logic                 busy;
   logic                 timeout_err;
   logic                 abort_err;
   logic [CNT_WIDTH-1:0] pkt_count;

   modport master (
      output req, last, xfer, enable,
      input  gnt, gnt_id, busy, timeout_err, abort_err, pkt_count
   );

   modport slave (
      input  req, last, xfer, enable,
      output gnt, gnt_id, busy, timeout_err, abort_err, pkt_count
   );
endinterface

// File: rtl/noc_port_arbiter.sv
// Wormhole round-robin arbiter for one NoC output port: holds a grant for a whole packet,
// with abort detection on dropped requests and an idle-stall watchdog.
module noc_port_arbiter #(
   parameter int unsigned NREQ      = 5,
   parameter int unsigned WD_MAX    = 255,
   parameter int unsigned CNT_WIDTH = 16
) (
   input logic                clk_i,
   input logic                reset_i,
   noc_port_arbiter_if.slave  bus
);
   localparam int unsigned IdW = 3;
   localparam int unsigned WdW = $clog2(WD_MAX + 1);

   typedef enum logic {StIdle, StGrant} state_e;

   state_e               state_q, state_d;
   logic [IdW-1:0]       gnt_id_q, gnt_id_d;
   logic [IdW-1:0]       ptr_q, ptr_d;
   logic [WdW-1:0]       wd_cnt_q, wd_cnt_d;
   logic                 timeout_q, timeout_d;
   logic                 abort_q, abort_d;
   logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

   logic [IdW-1:0]       win_id;
   logic                 win_found;
   logic [IdW-1:0]       ptr_next;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= StIdle;
         gnt_id_q  <= '0;
         ptr_q     <= '0;
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
         abort_q   <= 1'b0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_id_q  <= gnt_id_d;
         ptr_q     <= ptr_d;
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
         abort_q   <= abort_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   // First set request at or above ptr, wrapping back to requester 0.
   always_comb begin
      int unsigned idx;
      win_id    = '0;
      win_found = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_found && bus.req[idx]) begin
            win_found = 1'b1;
            win_id    = IdW'(idx);
         end
      end
   end

   assign ptr_next = (int'(gnt_id_q) == NREQ - 1) ? '0 : gnt_id_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      gnt_id_d  = gnt_id_q;
      ptr_d     = ptr_q;
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q;
      abort_d   = abort_q;
      pkt_cnt_d = pkt_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.enable && win_found) begin
               state_d  = StGrant;
               gnt_id_d = win_id;
               wd_cnt_d = '0;
            end
         end
         StGrant: begin
            // Release priority: tail transfer, then dropped request, then watchdog.
            if (bus.xfer && bus.last[gnt_id_q]) begin
               state_d   = StIdle;
               gnt_id_d  = '0;
               ptr_d     = ptr_next;
               wd_cnt_d  = '0;
               pkt_cnt_d = pkt_cnt_q + 1'b1;
            end else if (!bus.req[gnt_id_q]) begin
               state_d  = StIdle;
               gnt_id_d = '0;
               ptr_d    = ptr_next;
               wd_cnt_d = '0;
               abort_d  = 1'b1;
            end else if (!bus.xfer && (wd_cnt_q == WdW'(WD_MAX - 1))) begin
               state_d   = StIdle;
               gnt_id_d  = '0;
               ptr_d     = ptr_next;
               wd_cnt_d  = '0;
               timeout_d = 1'b1;
            end else begin
               wd_cnt_d = bus.xfer ? '0 : wd_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.busy        = (state_q == StGrant);
      bus.gnt_id      = bus.busy ? gnt_id_q : '0;
      bus.gnt         = bus.busy ? (NREQ'(1) << gnt_id_q) : '0;
      bus.timeout_err = timeout_q;
      bus.abort_err   = abort_q;
      bus.pkt_count   = pkt_cnt_q;
   end
endmodule

// File: tb/tb_noc_port_arbiter.sv
// Directed bench for noc_port_arbiter: round robin, wormhole lock, abort, watchdog,
// release precedence, reset and idle behaviour.
module tb_noc_port_arbiter;
   logic clk = 1'b0;
   logic reset_i;
   int   checks = 0;
   int   errors = 0;

   noc_port_arbiter_if #(.NREQ(5), .CNT_WIDTH(16)) bus ();

   noc_port_arbiter #(.NREQ(5), .WD_MAX(255), .CNT_WIDTH(16)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_i    = 1'b1;
      bus.req    = '0;
      bus.last   = '0;
      bus.xfer   = 1'b0;
      bus.enable = 1'b1;
      step();
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.req = 5'b11111; bus.xfer = 1'b1; bus.last = 5'b11111;
      reset_i = 1'b1;
      step();
      checks++; if (bus.gnt !== 5'b0) begin errors++; $display("FAIL reset_gnt: got %b expected %b", bus.gnt, 5'b0); end
      checks++; if (bus.gnt_id !== 3'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d expected 0", bus.gnt_id); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if ({bus.timeout_err, bus.abort_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {bus.timeout_err, bus.abort_err}); end
      checks++; if (bus.pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", bus.pkt_count); end
      reset_i = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [4:0] exp_gnt [6];
      exp_gnt = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      do_reset();
      bus.req = 5'b11111; bus.xfer = 1'b1; bus.last = 5'b11111;
      for (int k = 0; k < 6; k++) begin
         step();
         checks++; if (bus.gnt !== exp_gnt[k]) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", k, bus.gnt, exp_gnt[k]); end
         checks++; if (bus.gnt_id !== 3'(k % 5)) begin errors++; $display("FAIL rr_gnt_id%0d: got %0d expected %0d", k, bus.gnt_id, k % 5); end
         step();
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: got busy %b expected 0", k, bus.busy); end
         if (k == 4) begin
            checks++; if (bus.pkt_count !== 16'd5) begin errors++; $display("FAIL rr_pkt_count: got %0d expected 5", bus.pkt_count); end
         end
      end
   endtask

   task automatic test_wormhole();
      do_reset();
      bus.req = 5'b00100;
      step();
      checks++; if (bus.gnt !== 5'b00100) begin errors++; $display("FAIL wh_grant: got %b expected 00100", bus.gnt); end
      for (int f = 1; f <= 4; f++) begin
         bus.xfer = 1'b1;
         bus.last = (f == 4) ? 5'b00100 : 5'b00000;
         if (f == 2) bus.req = 5'b10100;
         bus.enable = (f != 3);
         step();
         if (f < 4) begin
            checks++; if (bus.gnt !== 5'b00100) begin errors++; $display("FAIL wh_lock_flit%0d: got %b expected 00100", f, bus.gnt); end
         end else begin
            checks++; if (bus.gnt !== 5'b00000) begin errors++; $display("FAIL wh_tail_release: got %b expected 00000", bus.gnt); end
         end
      end
      bus.xfer = 1'b0; bus.last = '0; bus.enable = 1'b1;
      step();
      checks++; if (bus.gnt !== 5'b10000) begin errors++; $display("FAIL wh_next_gnt: got %b expected 10000", bus.gnt); end
      checks++; if (bus.gnt_id !== 3'd4) begin errors++; $display("FAIL wh_next_id: got %0d expected 4", bus.gnt_id); end
   endtask

   task automatic test_abort();
      do_reset();
      bus.req = 5'b00010;
      step();
      checks++; if (bus.gnt !== 5'b00010) begin errors++; $display("FAIL ab_grant: got %b expected 00010", bus.gnt); end
      bus.xfer = 1'b1; bus.last = 5'b00000;
      step();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ab_body_flit: got busy %b expected 1", bus.busy); end
      bus.xfer = 1'b0; bus.req = 5'b00000;
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ab_release: got busy %b expected 0", bus.busy); end
      checks++; if (bus.abort_err !== 1'b1) begin errors++; $display("FAIL ab_flag: got %b expected 1", bus.abort_err); end
      checks++; if (bus.pkt_count !== 16'd0) begin errors++; $display("FAIL ab_pkt_count: got %0d expected 0", bus.pkt_count); end
      bus.req = 5'b11111;
      step();
      checks++; if (bus.gnt !== 5'b00100) begin errors++; $display("FAIL ab_ptr: got %b expected 00100", bus.gnt); end
      checks++; if (bus.abort_err !== 1'b1) begin errors++; $display("FAIL ab_sticky: got %b expected 1", bus.abort_err); end
   endtask

   task automatic test_watchdog();
      do_reset();
      bus.req = 5'b00001;
      step();
      repeat (254) step();
      checks++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL wd_stall254: got busy %b tmo %b expected 1 0", bus.busy, bus.timeout_err); end
      step();
      checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL wd_stall255: got busy %b tmo %b expected 0 1", bus.busy, bus.timeout_err); end
      checks++; if (bus.pkt_count !== 16'd0) begin errors++; $display("FAIL wd_pkt_count: got %0d expected 0", bus.pkt_count); end
      do_reset();
      checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL wd_flag_reset: got %b expected 0", bus.timeout_err); end
      bus.req = 5'b00001;
      step();
      repeat (200) step();
      bus.xfer = 1'b1;
      step();
      bus.xfer = 1'b0;
      repeat (254) step();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wd_delayed_hold: got busy %b expected 1", bus.busy); end
      step();
      checks++; if (bus.busy !== 1'b0 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL wd_delayed_release: got busy %b tmo %b expected 0 1", bus.busy, bus.timeout_err); end
   endtask

   task automatic test_precedence_reset();
      do_reset();
      bus.req = 5'b01000;
      step();
      checks++; if (bus.gnt !== 5'b01000) begin errors++; $display("FAIL pr_grant: got %b expected 01000", bus.gnt); end
      bus.xfer = 1'b1; bus.last = 5'b01000; bus.req = 5'b00000;
      step();
      checks++; if (bus.busy !== 1'b0 || bus.pkt_count !== 16'd1) begin errors++; $display("FAIL pr_tail_wins: got busy %b cnt %0d expected 0 1", bus.busy, bus.pkt_count); end
      checks++; if (bus.abort_err !== 1'b0) begin errors++; $display("FAIL pr_no_abort: got %b expected 0", bus.abort_err); end
      bus.xfer = 1'b0; bus.last = '0; bus.req = 5'b00010;
      step();
      checks++; if (bus.gnt !== 5'b00010) begin errors++; $display("FAIL pr_regrant: got %b expected 00010", bus.gnt); end
      reset_i = 1'b1;
      step();
      checks++; if ({bus.gnt, bus.gnt_id, bus.busy, bus.pkt_count} !== 25'd0) begin errors++; $display("FAIL pr_mid_reset: got gnt %b id %0d busy %b cnt %0d expected all 0", bus.gnt, bus.gnt_id, bus.busy, bus.pkt_count); end
      reset_i = 1'b0; bus.req = 5'b11111;
      step();
      checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL pr_ptr_after_reset: got %b expected 00001", bus.gnt); end
   endtask

   task automatic test_idle_ignore();
      do_reset();
      bus.xfer = 1'b1; bus.last = 5'b11111;
      repeat (3) step();
      checks++; if (bus.busy !== 1'b0 || bus.pkt_count !== 16'd0) begin errors++; $display("FAIL idle_ignore: got busy %b cnt %0d expected 0 0", bus.busy, bus.pkt_count); end
      bus.xfer = 1'b0; bus.last = '0; bus.enable = 1'b0; bus.req = 5'b00100;
      step();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL enable_block: got busy %b expected 0", bus.busy); end
      bus.enable = 1'b1;
      step();
      checks++; if (bus.gnt !== 5'b00100) begin errors++; $display("FAIL enable_grant: got %b expected 00100", bus.gnt); end
   endtask

   initial begin
      reset_i    = 1'b1;
      bus.req    = '0;
      bus.last   = '0;
      bus.xfer   = 1'b0;
      bus.enable = 1'b1;
      test_reset();
      test_round_robin();
      test_wormhole();
      test_abort();
      test_watchdog();
      test_precedence_reset();
      test_idle_ignore();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
